pool_wb_rtm_wr_mc: RTL and testbench
====================================

# pool_wb_rtm_wr_mc

Parametrised write-back stage for the pooling core that pairs gathered output rows with write-back descriptors and writes them into the RTM. It replaces the fixed two-cycle data/descriptor alignment with an internal data FIFO, so data and descriptors arrive independently. It adds per-slot write masking, backpressure toward the gather stage, a job-level descriptor counter, an overflow flag and a programmable done delay. It sits between the pool gather unit / write-back descriptor FIFO and the RTM write ports.

## Interface
- S, 8, number of RTM slots (parallel write lanes)
- R, 8, bytes per slot per row
- ADDR_W, 12, RTM address width (clog2 of RTM depth)
- DFIFO_DEPTH, 8, internal data FIFO entries; power of two, >= 2
- DONE_DLY, 5, cycles from the last-descriptor RTM write to done_pulse; >= 1
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- gathered_data  in  S*R*8  gathered row, slot i in bits [i*R*8 +: R*8]
- gathered_data_vld  in  1  row valid; accepted only when data_ready=1
- data_ready  out  1  data FIFO not full
- desc_fifo_empty  in  1  descriptor FIFO (first-word fall-through) empty
- desc_fifo_rd_en  out  1  pop descriptor; combinational
- desc_fifo_dout_addr  in  ADDR_W  RTM row address
- desc_fifo_dout_mask  in  S  per-slot skip mask, 1 = do not write slot
- desc_fifo_dout_last  in  1  last descriptor of the job
- rtm_wr_vld  out  1  one write slot consumed this cycle
- rtm_wr_en  out  S  per-slot write enable
- rtm_wr_addr  out  S*ADDR_W  address replicated per slot
- rtm_din  out  S*R*8  write data
- done_pulse  out  1  one-cycle job completion pulse
- wr_cnt  out  16  descriptors consumed in the current job
- err_ovf  out  1  sticky: vld seen while data_ready=0

## Operation
- Data FIFO: push when gathered_data_vld && data_ready; read/write pointers wrap modulo DFIFO_DEPTH; occupancy counter 0..DFIFO_DEPTH.
- data_ready = (occupancy != DFIFO_DEPTH) && !rst. A push is refused when full, even if a pop occurs in the same cycle.
- gathered_data_vld while data_ready=0: the row is dropped and err_ovf is set; err_ovf clears only on rst.
- FSM states: RUN, DONE_WAIT.
- RUN: pop = !desc_fifo_empty && occupancy != 0. desc_fifo_rd_en = pop. A pop also dequeues one data row.
- A pop with desc_fifo_dout_last=1 moves to DONE_WAIT and loads the delay counter with DONE_DLY-1.
- DONE_WAIT: desc_fifo_rd_en=0 and no data pops. Data pushes continue. The counter decrements each cycle; at 0, done_pulse=1 for that cycle, wr_cnt clears to 0 and the FSM returns to RUN.
- Pop in cycle t, registered outputs in t+1:
  - rtm_wr_vld=1
  - rtm_wr_en[i] = ~mask[i]
  - every rtm_wr_addr lane = addr
  - rtm_din = FIFO head row
- A fully masked descriptor still consumes a row: rtm_wr_vld=1, rtm_wr_en=0.
- No pop in a cycle: rtm_wr_vld=0 and rtm_wr_en=0 next cycle; rtm_wr_addr/rtm_din hold their last values.
- wr_cnt increments per pop, saturating at 0xFFFF.

## Timing
- Reset (async assert, sync release): FSM=RUN, FIFO empty, and all outputs 0: rtm_*, done_pulse, wr_cnt, err_ovf, desc_fifo_rd_en. data_ready=0 during rst and 1 after release.
- Reset mid-job discards FIFO contents and any pending done. Outstanding descriptors remain in the external FIFO.
- Latency: a push at edge t makes the row visible at t+1; pop at t+1; RTM write presented at t+2. Back-to-back rows: one write per cycle sustained.
- Last write presented at cycle T gives done_pulse at T+DONE_DLY. The earliest next-job pop is at T+DONE_DLY.

## Test plan
- S=8, DFIFO_DEPTH=8: 4 rows then 4 descriptors (addr 0x10..0x13, mask 0, last on 4th) -> 4 consecutive writes with rtm_wr_en=0xFF and correct data/addr; done_pulse exactly 5 cycles after the 4th write; wr_cnt 4 then 0.
- Descriptors first, rows 3 cycles later -> no rd_en before data arrives; each write appears 2 cycles after its row push.
- Mask 0xA5 on one descriptor -> rtm_wr_en=0x5A for that write; mask 0xFF -> rtm_wr_vld=1, rtm_wr_en=0, row consumed.
- Hold desc_fifo_empty=1 and push 9 rows -> data_ready falls after the 8th row; the 9th is dropped and err_ovf=1 stays set. After 8 pops, data_ready=1 and the 8 rows are written in order, exercising pointer wrap.
- Job boundary: last on descriptor 2 with descriptor 3 queued -> no pop during DONE_WAIT; descriptor 3 pops in the done_pulse cycle.
- Assert rst mid-job with 3 rows queued -> all outputs 0 immediately; FIFO empty after release; no done_pulse emitted.

Source files
------------

// File: rtl/pool_wb_rtm_wr_mc.sv
// Pooling write-back stage: pairs gathered rows (buffered in a local FIFO)
// with write-back descriptors and issues masked RTM row writes.
module pool_wb_rtm_wr_mc #(
    parameter int S           = 8,
    parameter int R           = 8,
    parameter int ADDR_W      = 12,
    parameter int DFIFO_DEPTH = 8,
    parameter int DONE_DLY    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [S*R*8-1:0]      gathered_data,
    input  logic                  gathered_data_vld,
    output logic                  data_ready,
    input  logic                  desc_fifo_empty,
    output logic                  desc_fifo_rd_en,
    input  logic [ADDR_W-1:0]     desc_fifo_dout_addr,
    input  logic [S-1:0]          desc_fifo_dout_mask,
    input  logic                  desc_fifo_dout_last,
    output logic                  rtm_wr_vld,
    output logic [S-1:0]          rtm_wr_en,
    output logic [S*ADDR_W-1:0]   rtm_wr_addr,
    output logic [S*R*8-1:0]      rtm_din,
    output logic                  done_pulse,
    output logic [15:0]           wr_cnt,
    output logic                  err_ovf
);

    localparam int DW = S * R * 8;
    localparam int PW = $clog2(DFIFO_DEPTH);
    localparam int OW = PW + 1;
    localparam int CW = $clog2(DONE_DLY + 1);
    localparam logic [OW-1:0] FULL = OW'(DFIFO_DEPTH);

    typedef enum logic {
        RUN,
        DONE_WAIT
    } state_t;

    state_t        state;
    logic [DW-1:0] mem [DFIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [OW-1:0] occ;
    logic [CW-1:0] dly;
    logic          push;
    logic          pop;

    assign data_ready      = (occ != FULL) && !rst;
    assign push            = gathered_data_vld && data_ready;
    assign pop             = (state == RUN) && !desc_fifo_empty && (occ != '0);
    assign desc_fifo_rd_en = pop;

    // Row storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= gathered_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            wptr        <= '0;
            rptr        <= '0;
            occ         <= '0;
            dly         <= '0;
            rtm_wr_vld  <= 1'b0;
            rtm_wr_en   <= '0;
            rtm_wr_addr <= '0;
            rtm_din     <= '0;
            done_pulse  <= 1'b0;
            wr_cnt      <= '0;
            err_ovf     <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            occ <= occ + OW'(push) - OW'(pop);

            if (gathered_data_vld && !data_ready) begin
                err_ovf <= 1'b1;
            end

            rtm_wr_vld <= pop;
            rtm_wr_en  <= pop ? ~desc_fifo_dout_mask : '0;
            if (pop) begin
                rtm_wr_addr <= {S{desc_fifo_dout_addr}};
                rtm_din     <= mem[rptr];
            end

            done_pulse <= 1'b0;
            unique case (state)
                RUN: begin
                    if (pop) begin
                        if (wr_cnt != 16'hFFFF) begin
                            wr_cnt <= wr_cnt + 16'd1;
                        end
                        if (desc_fifo_dout_last) begin
                            state <= DONE_WAIT;
                            dly   <= CW'(DONE_DLY - 1);
                        end
                    end
                end
                DONE_WAIT: begin
                    // Pulse lands DONE_DLY cycles after the last write shows up.
                    if (dly == '0) begin
                        state      <= RUN;
                        done_pulse <= 1'b1;
                        wr_cnt     <= '0;
                    end else begin
                        dly <= dly - 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_wb_rtm_wr_mc.sv
// Self-checking bench for pool_wb_rtm_wr_mc: scoreboard of row/descriptor
// pairs plus cycle-accurate checks of latency, masking, overflow and done.
module tb_pool_wb_rtm_wr_mc;

    localparam int S   = 8;
    localparam int R   = 8;
    localparam int AW  = 12;
    localparam int DEP = 8;
    localparam int DLY = 5;
    localparam int DW  = S * R * 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [S-1:0]  mask;
        logic          last;
    } desc_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [S-1:0]  en;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [S-1:0]  mask;
        logic          last;
        logic [S-1:0]  exp_en;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   gathered_data;
    logic            gathered_data_vld;
    logic            data_ready;
    logic            desc_fifo_empty;
    logic            desc_fifo_rd_en;
    logic [AW-1:0]   desc_fifo_dout_addr;
    logic [S-1:0]    desc_fifo_dout_mask;
    logic            desc_fifo_dout_last;
    logic            rtm_wr_vld;
    logic [S-1:0]    rtm_wr_en;
    logic [S*AW-1:0] rtm_wr_addr;
    logic [DW-1:0]   rtm_din;
    logic            done_pulse;
    logic [15:0]     wr_cnt;
    logic            err_ovf;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int rowk   = 0;

    desc_t dmem [64];
    int    dwr = 0;
    int    drd = 0;

    logic [DW-1:0] row_q [$];
    desc_t         desc_q [$];
    wr_t           exp_q [$];
    int            wr_cyc_q [$];
    int            push_cyc_q [$];
    int            done_cyc_q [$];
    logic [S-1:0]  wr_en_q [$];
    logic [15:0]   wr_cnt_q [$];
    wr_t           e_mon;
    vec_t          tbl [4];

    always #5 clk = ~clk;

    pool_wb_rtm_wr_mc #(
        .S(S), .R(R), .ADDR_W(AW), .DFIFO_DEPTH(DEP), .DONE_DLY(DLY)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .gathered_data       (gathered_data),
        .gathered_data_vld   (gathered_data_vld),
        .data_ready          (data_ready),
        .desc_fifo_empty     (desc_fifo_empty),
        .desc_fifo_rd_en     (desc_fifo_rd_en),
        .desc_fifo_dout_addr (desc_fifo_dout_addr),
        .desc_fifo_dout_mask (desc_fifo_dout_mask),
        .desc_fifo_dout_last (desc_fifo_dout_last),
        .rtm_wr_vld          (rtm_wr_vld),
        .rtm_wr_en           (rtm_wr_en),
        .rtm_wr_addr         (rtm_wr_addr),
        .rtm_din             (rtm_din),
        .done_pulse          (done_pulse),
        .wr_cnt              (wr_cnt),
        .err_ovf             (err_ovf)
    );

    // External first-word-fall-through descriptor FIFO
    assign desc_fifo_empty     = (dwr == drd);
    assign desc_fifo_dout_addr = dmem[drd % 64].addr;
    assign desc_fifo_dout_mask = dmem[drd % 64].mask;
    assign desc_fifo_dout_last = dmem[drd % 64].last;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (desc_fifo_rd_en) drd <= drd + 1;
    end

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rtm_wr_vld) begin
                wr_cyc_q.push_back(cyc);
                wr_en_q.push_back(rtm_wr_en);
                wr_cnt_q.push_back(wr_cnt);
                check("write_expected", DW'(exp_q.size() != 0), DW'(1));
                if (exp_q.size() != 0) begin
                    e_mon = exp_q.pop_front();
                    check("wr_en", DW'(rtm_wr_en), DW'(e_mon.en));
                    check("wr_addr", DW'(rtm_wr_addr), DW'({S{e_mon.addr}}));
                    check("wr_data", rtm_din, e_mon.data);
                end
            end else begin
                check("idle_wr_en", DW'(rtm_wr_en), DW'(0));
            end
            if (done_pulse) done_cyc_q.push_back(cyc);
        end
    end

    function automatic logic [DW-1:0] mkrow(input int k);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++)
            d[i*32 +: 32] = {k[7:0], i[7:0], 16'hC35A} ^ (k * 32'h9E3779B9);
        return d;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pair();
        wr_t w;
        desc_t d;
        while (row_q.size() != 0 && desc_q.size() != 0) begin
            d = desc_q.pop_front();
            w.addr = d.addr;
            w.en   = ~d.mask;
            w.data = row_q.pop_front();
            exp_q.push_back(w);
        end
    endtask

    task automatic clearq();
        row_q.delete(); desc_q.delete(); exp_q.delete();
        wr_cyc_q.delete(); push_cyc_q.delete(); done_cyc_q.delete();
        wr_en_q.delete(); wr_cnt_q.delete();
    endtask

    task automatic push_row(input bit acc);
        logic [DW-1:0] d;
        d = mkrow(rowk);
        rowk++;
        gathered_data     = d;
        gathered_data_vld = 1'b1;
        push_cyc_q.push_back(cyc);
        if (acc) row_q.push_back(d);
        pair();
        step();
        gathered_data_vld = 1'b0;
    endtask

    task automatic push_desc(input logic [AW-1:0] a, input logic [S-1:0] m,
                             input logic l);
        desc_t d;
        d = '{addr: a, mask: m, last: l};
        dmem[dwr % 64] = d;
        dwr++;
        desc_q.push_back(d);
        pair();
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && wr_cyc_q.size() < n; i++) step();
        check("write_count", DW'(wr_cyc_q.size()), DW'(n));
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget && done_cyc_q.size() < n; i++) step();
        check("done_count", DW'(done_cyc_q.size()), DW'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{addr: 12'h030, mask: 8'hA5, last: 1'b0, exp_en: 8'h5A};
        tbl[1] = '{addr: 12'h031, mask: 8'hFF, last: 1'b0, exp_en: 8'h00};
        tbl[2] = '{addr: 12'h032, mask: 8'h0F, last: 1'b0, exp_en: 8'hF0};
        tbl[3] = '{addr: 12'h033, mask: 8'h00, last: 1'b1, exp_en: 8'hFF};

        rst = 1'b1;
        gathered_data_vld = 1'b0;
        gathered_data = '0;
        step(2);
        check("rst_wr_vld", DW'(rtm_wr_vld), DW'(0));
        check("rst_wr_en", DW'(rtm_wr_en), DW'(0));
        check("rst_wr_addr", DW'(rtm_wr_addr), DW'(0));
        check("rst_din", rtm_din, DW'(0));
        check("rst_done", DW'(done_pulse), DW'(0));
        check("rst_wr_cnt", DW'(wr_cnt), DW'(0));
        check("rst_err_ovf", DW'(err_ovf), DW'(0));
        check("rst_rd_en", DW'(desc_fifo_rd_en), DW'(0));
        check("rst_data_ready", DW'(data_ready), DW'(0));
        rst = 1'b0;
        step();
        check("post_rst_data_ready", DW'(data_ready), DW'(1));

        // Rows first, then a 4-descriptor job
        clearq();
        for (int k = 0; k < 4; k++) push_row(1'b1);
        for (int k = 0; k < 4; k++) push_desc(AW'(12'h010 + k), 8'h00, k == 3);
        wait_writes(4, 20);
        check("t1_back_to_back", DW'(wr_cyc_q[3] - wr_cyc_q[0]), DW'(3));
        check("t1_cnt_first", DW'(wr_cnt_q[0]), DW'(1));
        check("t1_cnt_last", DW'(wr_cnt_q[3]), DW'(4));
        wait_done(1, 30);
        check("t1_done_delay", DW'(done_cyc_q[0] - wr_cyc_q[3]), DW'(DLY));
        check("t1_cnt_cleared", DW'(wr_cnt), DW'(0));

        // Descriptors first, rows three cycles later
        clearq();
        push_desc(12'h020, 8'h00, 1'b0);
        push_desc(12'h021, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("t2_no_rd_en", DW'(desc_fifo_rd_en), DW'(0));
            step();
        end
        push_cyc_q.delete();
        push_row(1'b1);
        push_row(1'b1);
        wait_writes(2, 20);
        check("t2_lat0", DW'(wr_cyc_q[0] - push_cyc_q[0]), DW'(2));
        check("t2_lat1", DW'(wr_cyc_q[1] - push_cyc_q[1]), DW'(2));
        wait_done(1, 30);

        // Table-driven masks
        clearq();
        for (int i = 0; i < 4; i++) begin
            push_row(1'b1);
            push_desc(tbl[i].addr, tbl[i].mask, tbl[i].last);
            wait_writes(i + 1, 20);
            check($sformatf("mask_en_%0d", i), DW'(wr_en_q[i]), DW'(tbl[i].exp_en));
            check($sformatf("mask_cnt_%0d", i), DW'(wr_cnt_q[i]), DW'(i + 1));
        end
        wait_done(1, 30);

        // Overflow and pointer wrap
        clearq();
        check("t4_ovf_clear", DW'(err_ovf), DW'(0));
        for (int k = 0; k < 8; k++) push_row(1'b1);
        check("t4_full", DW'(data_ready), DW'(0));
        push_row(1'b0);
        check("t4_ovf_set", DW'(err_ovf), DW'(1));
        step(3);
        check("t4_ovf_sticky", DW'(err_ovf), DW'(1));
        check("t4_still_full", DW'(data_ready), DW'(0));
        for (int k = 0; k < 8; k++) push_desc(AW'(12'h100 + k), 8'h00, k == 7);
        wait_writes(8, 40);
        check("t4_ready_again", DW'(data_ready), DW'(1));
        check("t4_streaming", DW'(wr_cyc_q[7] - wr_cyc_q[0]), DW'(7));
        wait_done(1, 30);
        check("t4_ovf_kept", DW'(err_ovf), DW'(1));

        // Job boundary with next job's descriptor already queued
        clearq();
        for (int k = 0; k < 3; k++) push_row(1'b1);
        push_desc(12'h040, 8'h00, 1'b0);
        push_desc(12'h041, 8'h00, 1'b1);
        push_desc(12'h042, 8'h00, 1'b1);
        wait_writes(3, 40);
        check("t5_pair", DW'(wr_cyc_q[1] - wr_cyc_q[0]), DW'(1));
        check("t5_done1", DW'(done_cyc_q[0] - wr_cyc_q[1]), DW'(DLY));
        check("t5_pop_in_done", DW'(wr_cyc_q[2] - done_cyc_q[0]), DW'(1));
        wait_done(2, 30);
        check("t5_done2", DW'(done_cyc_q[1] - wr_cyc_q[2]), DW'(DLY));

        // Reset during a pending done with three rows still queued
        clearq();
        for (int k = 0; k < 4; k++) push_row(1'b1);
        push_desc(12'h050, 8'h00, 1'b1);
        wait_writes(1, 20);
        step();
        rst = 1'b1;
        #1;
        check("t6_wr_vld", DW'(rtm_wr_vld), DW'(0));
        check("t6_din", rtm_din, DW'(0));
        check("t6_addr", DW'(rtm_wr_addr), DW'(0));
        check("t6_cnt", DW'(wr_cnt), DW'(0));
        check("t6_ready", DW'(data_ready), DW'(0));
        check("t6_err", DW'(err_ovf), DW'(0));
        clearq();
        step(2);
        rst = 1'b0;
        step();
        check("t6_ready_after", DW'(data_ready), DW'(1));
        push_desc(12'h060, 8'h3C, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("t6_fifo_empty", DW'(desc_fifo_rd_en), DW'(0));
            step();
        end
        check("t6_no_done", DW'(done_cyc_q.size()), DW'(0));
        push_row(1'b1);
        wait_writes(1, 20);
        wait_done(1, 30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
